uart_rx_os: RTL
===============

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of 2, >= 4).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud ticks per bit (fixed at 16; other values unsupported).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rx_rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have these ports:
- baud_div  input  16  clk cycles per baud tick; bit period = baud_div*16 clk; 0 treated as 1.
- rx  input  1  serial line, asynchronous.
- data_length  input  4  data bits 5..8; any other value treated as 8.
- check  input  1  parity bit present.
- parity_mode  input  2  00 even, 01 odd, 10 stick-0, 11 stick-1.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- rx_fifo_read  input  1  pop FIFO head.
- fifo_clr  input  1  synchronous FIFO flush.
- p_error_ack, st_error_ack, ovr_ack  input  1 each  clear the matching flag.
- data_to_reg  output  8  FIFO head, first-word fall-through.
- rx_fifo_cnt  output  log2(FIFO_DEPTH)+1  occupancy.
- rx_fifo_empty, rx_fifo_full  output  1 each  FIFO status.
- p_error, st_error, overrun, break_det  output  1 each  sticky error flags.
- rx_work  output  1  frame in progress.

Function
REQ-006 SHALL pass rx through a 2-flop synchroniser; all sampling uses the synchronised value.
REQ-007 SHALL generate a one-clk baud tick every baud_div clk. The tick counter SHALL restart on start-edge detection.
REQ-008 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
- PARITY is skipped when check=0.
- STOP2 is skipped when stop_bits=0.
REQ-009 SHALL leave IDLE on a 1->0 transition of the synchronised rx.
REQ-010 SHALL take each bit value as the majority of samples at ticks 7, 8 and 9 of that bit.
REQ-011 SHALL treat a start bit whose majority is 1 as a false start: return to IDLE with no FIFO write and no flag change.
REQ-012 SHALL receive data LSB first; unused upper bits of the byte SHALL be 0.
REQ-013 SHALL set p_error on parity mismatch. Expected parity bit:
- even: ^data
- odd: ~^data
- stick-0: 0
- stick-1: 1
REQ-014 SHALL set st_error if any stop-bit majority is 0.
REQ-015 SHALL write the byte to the FIFO one clk after the tick-9 sample of the last stop bit, even when p_error or st_error is set.
REQ-016 SHALL return to IDLE after the last stop-bit sample. This is a half-bit early exit, allowing back-to-back frames.
REQ-017 SHALL drive rx_work high in every state except IDLE.
REQ-018 SHALL, on a write while full with no same-cycle read, discard the byte and set overrun.
REQ-019 SHALL perform a simultaneous read and write when full; the count is unchanged and overrun is not set.
REQ-020 SHALL ignore rx_fifo_read when the FIFO is empty.
REQ-021 SHALL drive data_to_reg to 0 when the FIFO is empty.
REQ-022 SHALL update rx_fifo_cnt, rx_fifo_empty and rx_fifo_full one clk after the push or pop.
REQ-023 SHALL hold each sticky flag until its ack is high.
- If ack and a new set event occur in the same clk, set wins.
REQ-024 SHALL, on fifo_clr, empty the FIFO and leave flags and the FSM unaffected. If fifo_clr and a write occur in the same clk, clear wins.

Reset
REQ-025 SHALL, while rx_rstn=0, immediately force the FSM to IDLE and flush the FIFO, including mid-frame.
REQ-026 SHALL hold these reset values:
- all flags 0
- rx_work 0
- rx_fifo_cnt 0
- rx_fifo_empty 1
- rx_fifo_full 0
- data_to_reg 0
- synchroniser flops 1

Configuration
REQ-027 SHALL implement break detection only when UART_RX_BREAK_DET_EN is defined. A break frame is one with every sampled bit 0, including parity and stop.
- Defined: set break_det and st_error, push one 0x00, then wait in STOP1 until synchronised rx=1 before returning to IDLE.
- Undefined: break_det SHALL be constant 0; the frame SHALL be handled as an ordinary frame with st_error.

Verification
REQ-028 SHALL cover: baud_div=25, 8 bits, even parity, bytes 0x00..0x11 back-to-back, no reads -> first 16 stored, rx_fifo_cnt=16, rx_fifo_full=1, overrun=1, data_to_reg=0x00.
REQ-029 SHALL cover: 0xA5 sent with parity bit 1 in even mode -> p_error=1, 0xA5 stored; p_error=0 one clk after a 1-clk p_error_ack.
REQ-030 SHALL cover: a 3-clk low glitch on rx -> rx_fifo_cnt stays 0, all flags 0, rx_work back to 0 within 10 baud ticks.
REQ-031 SHALL cover: stop_bits=1, 7 bits, byte 0x55, second stop bit 0 -> st_error=1, 0x55 stored.
REQ-032 SHALL cover: rx held low for 12 bit times -> with the macro, break_det=1, st_error=1 and one 0x00 stored; without it, break_det=0, st_error=1 and one 0x00 stored.
REQ-033 SHALL cover: rx_rstn asserted in the middle of the DATA state with 3 bytes queued -> rx_fifo_cnt=0, rx_fifo_empty=1, rx_work=0; the next frame after release is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with a first-word-fall-through receive FIFO and sticky error flags.
// Break detection is compiled in only when UART_RX_BREAK_DET_EN is defined.
module uart_rx_os #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          rx_rstn,
    input  logic [15:0]                   baud_div,
    input  logic                          rx,
    input  logic [3:0]                    data_length,
    input  logic                          check,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          rx_fifo_read,
    input  logic                          fifo_clr,
    input  logic                          p_error_ack,
    input  logic                          st_error_ack,
    input  logic                          ovr_ack,
    output logic [7:0]                    data_to_reg,
    output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_cnt,
    output logic                          rx_fifo_empty,
    output logic                          rx_fifo_full,
    output logic                          p_error,
    output logic                          st_error,
    output logic                          overrun,
    output logic                          break_det,
    output logic                          rx_work
);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t      state_reg, state_next;
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [15:0] div_eff, div_cnt_reg;
    logic [3:0]  tick_cnt_reg;
    logic        s7_reg, s8_reg;
    logic        start_edge, baud_tick, samp_tick, bit_end, maj;
    logic [2:0]  bit_idx_reg, last_idx;
    logic [7:0]  data_reg;
    logic        exp_par;
    logic        frame_done, wr_pending_reg;
    logic        p_err_set, st_err_set, ovr_set;
    logic        p_error_reg, st_error_reg, overrun_reg;
`ifdef UART_RX_BREAK_DET_EN
    logic        brk_set, brk_wait_reg, all_zero_reg, break_det_reg;
`endif

    // FIFO storage and pointers
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
    logic [AW:0]   cnt_reg, cnt_next;
    logic [7:0]    head_reg;
    logic          rd_ok, push_ok;

    always_ff @(posedge clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign div_eff    = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign start_edge = (state_reg == IDLE) && rx_prev_reg && !rx_sync_reg;
    assign baud_tick  = !start_edge && (div_cnt_reg >= div_eff - 16'd1);
    assign samp_tick  = baud_tick && (tick_cnt_reg == 4'd9);
    assign bit_end    = baud_tick && (tick_cnt_reg == LAST_TICK);
    assign maj        = (s7_reg & s8_reg) | (s7_reg & rx_sync_reg) | (s8_reg & rx_sync_reg);

    // Baud divider restarts on the start edge so every bit is timed from the detected edge.
    always_ff @(posedge clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            div_cnt_reg  <= 16'd0;
            tick_cnt_reg <= 4'd0;
            s7_reg       <= 1'b1;
            s8_reg       <= 1'b1;
        end else begin
            if (start_edge || baud_tick)
                div_cnt_reg <= 16'd0;
            else
                div_cnt_reg <= div_cnt_reg + 16'd1;
            if (state_reg == IDLE)
                tick_cnt_reg <= 4'd0;
            else if (baud_tick)
                tick_cnt_reg <= tick_cnt_reg + 4'd1;
            if (baud_tick && tick_cnt_reg == 4'd7)
                s7_reg <= rx_sync_reg;
            if (baud_tick && tick_cnt_reg == 4'd8)
                s8_reg <= rx_sync_reg;
        end
    end

    always_comb begin
        last_idx = 3'd7;
        if (data_length >= 4'd5 && data_length <= 4'd7)
            last_idx = 3'(data_length - 4'd1);
    end

    always_comb begin
        case (parity_mode)
            2'b00:   exp_par = ^data_reg;
            2'b01:   exp_par = ~^data_reg;
            2'b10:   exp_par = 1'b0;
            default: exp_par = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rx_rstn) begin
        if (!rx_rstn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        frame_done = 1'b0;
        p_err_set  = 1'b0;
        st_err_set = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_set    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (start_edge)
                    state_next = START;
            end
            START: begin
                if (samp_tick && maj)
                    state_next = IDLE;
                else if (bit_end)
                    state_next = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx_reg == last_idx)
                    state_next = check ? PARITY : STOP1;
            end
            PARITY: begin
                if (samp_tick && (maj != exp_par))
                    p_err_set = 1'b1;
                if (bit_end)
                    state_next = STOP1;
            end
            STOP1: begin
`ifdef UART_RX_BREAK_DET_EN
                if (brk_wait_reg) begin
                    if (rx_sync_reg)
                        state_next = IDLE;
                end else if (samp_tick && !maj && all_zero_reg) begin
                    brk_set    = 1'b1;
                    st_err_set = 1'b1;
                    frame_done = 1'b1;
                end else
`endif
                if (samp_tick) begin
                    st_err_set = !maj;
                    if (!stop_bits) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end
                end else if (bit_end && stop_bits) begin
                    state_next = STOP2;
                end
            end
            STOP2: begin
                if (samp_tick) begin
                    st_err_set = !maj;
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift-in datapath; the FIFO push trails the final stop sample by one clk.
    always_ff @(posedge clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            data_reg       <= 8'd0;
            bit_idx_reg    <= 3'd0;
            wr_pending_reg <= 1'b0;
        end else begin
            wr_pending_reg <= frame_done;
            if (start_edge) begin
                data_reg    <= 8'd0;
                bit_idx_reg <= 3'd0;
            end else if (state_reg == DATA) begin
                if (samp_tick)
                    data_reg[bit_idx_reg] <= maj;
                if (bit_end)
                    bit_idx_reg <= bit_idx_reg + 3'd1;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            all_zero_reg <= 1'b1;
            brk_wait_reg <= 1'b0;
        end else begin
            if (start_edge)
                all_zero_reg <= 1'b1;
            else if ((state_reg == DATA || state_reg == PARITY) && samp_tick && maj)
                all_zero_reg <= 1'b0;
            if (brk_set)
                brk_wait_reg <= 1'b1;
            else if (state_reg != STOP1)
                brk_wait_reg <= 1'b0;
        end
    end
`endif

    assign rd_ok      = rx_fifo_read && (cnt_reg != '0);
    assign push_ok    = wr_pending_reg && !fifo_clr && ((cnt_reg != DEPTH_CNT) || rd_ok);
    assign ovr_set    = wr_pending_reg && !fifo_clr && (cnt_reg == DEPTH_CNT) && !rd_ok;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign cnt_next   = cnt_reg + (AW+1)'(push_ok) - (AW+1)'(rd_ok);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= data_reg;
    end

    // Head register is loaded from the next read address, bypassing the write when the FIFO runs dry.
    always_ff @(posedge clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            head_reg   <= 8'd0;
        end else if (fifo_clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            head_reg   <= 8'd0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok)
                rd_ptr_reg <= rd_ptr_inc;
            cnt_reg <= cnt_next;
            if (cnt_next == '0)
                head_reg <= 8'd0;
            else if (push_ok && (cnt_reg == '0 || (rd_ok && cnt_reg == (AW+1)'(1))))
                head_reg <= data_reg;
            else if (rd_ok)
                head_reg <= mem[rd_ptr_inc];
        end
    end

    // Set wins over a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            p_error_reg  <= 1'b0;
            st_error_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            p_error_reg  <= p_err_set  | (p_error_reg  & ~p_error_ack);
            st_error_reg <= st_err_set | (st_error_reg & ~st_error_ack);
            overrun_reg  <= ovr_set    | (overrun_reg  & ~ovr_ack);
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // A break is a framing error, so it shares the stop-error acknowledge.
    always_ff @(posedge clk or negedge rx_rstn) begin
        if (!rx_rstn)
            break_det_reg <= 1'b0;
        else
            break_det_reg <= brk_set | (break_det_reg & ~st_error_ack);
    end
    assign break_det = break_det_reg;
`else
    assign break_det = 1'b0;
`endif

    assign data_to_reg   = head_reg;
    assign rx_fifo_cnt   = cnt_reg;
    assign rx_fifo_empty = (cnt_reg == '0);
    assign rx_fifo_full  = (cnt_reg == DEPTH_CNT);
    assign p_error       = p_error_reg;
    assign st_error      = st_error_reg;
    assign overrun       = overrun_reg;
    assign rx_work       = (state_reg != IDLE);

endmodule
